gray_codec: RTL and testbench
=============================

Name: gray_codec

Overview:
- Registered binary/Gray-code converter with two independent channels.
- Binary-to-Gray channel: encodes a binary word, with a parity flag.
- Gray-to-binary channel: decodes a Gray word and flags non-unit Gray steps between consecutive valid inputs.
- Used at clock-domain-crossing pointers (FIFO read/write pointers) and in position encoders; sits between the counter and the synchroniser or consumer.

Parameters:
- WIDTH, 4, data width in bits of every data port; legal range WIDTH >= 1; WIDTH < 1 is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active high.
- b2g_valid_in  in  1  qualifies b2g_bin_in.
- b2g_bin_in  in  WIDTH  binary word to encode.
- b2g_valid_out  out  1  b2g_gray_out and b2g_parity hold a new result.
- b2g_gray_out  out  WIDTH  Gray code of the captured binary word.
- b2g_parity  out  1  XOR-reduction of b2g_gray_out.
- g2b_valid_in  in  1  qualifies g2b_gray_in.
- g2b_gray_in  in  WIDTH  Gray word to decode.
- g2b_valid_out  out  1  g2b_bin_out and g2b_step_err hold a new result.
- g2b_bin_out  out  WIDTH  binary value of the captured Gray word.
- g2b_step_err  out  1  captured word is not exactly 1 bit away from the previous valid word.

Behaviour:
- Encode function: gray = bin ^ (bin >> 1); MSB passes through unchanged.
- Decode function: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] ^ gray[i] for i = WIDTH-2 down to 0.
  - Equivalently, bin[i] = XOR of gray[WIDTH-1:i].
- Round trip: decode(encode(x)) == x for all 2^WIDTH values of x.
- WIDTH = 1: both functions are identity.
- Parity: b2g_parity = ^b2g_gray_out, which always equals bit 0 of the encoded binary word. It is registered with the data, not derived combinationally from the output.
- Latency: exactly 1 clock per channel. No back-pressure; a result is produced every cycle its valid_in is high.
- Clock behaviour, B2G channel:
  - b2g_valid_in high at a rising edge: capture the result and set b2g_valid_out = 1.
  - b2g_valid_in low: b2g_valid_out = 0; data and parity hold their last value.
- Clock behaviour, G2B channel: same rules as B2G, using g2b_valid_in, g2b_valid_out and g2b_bin_out.
- The two channels are fully independent; simultaneous activity on both is legal.
- Step checker:
  - Stores the last valid g2b_gray_in plus a have_prev flag.
  - On a valid input with have_prev = 1: g2b_step_err = 1 iff the Hamming distance between the new and stored word is not 1. Repeated codes (distance 0) are errors.
  - On a valid input with have_prev = 0 (the first word after reset): g2b_step_err = 0, then have_prev is set.
  - Wrap-around from the maximum count back to 0 (e.g. 1000 -> 0000 for WIDTH = 4) is distance 1 and is not an error.
  - g2b_step_err is a 1-cycle pulse aligned with g2b_valid_out and is 0 whenever g2b_valid_out is 0.
  - Non-valid cycles do not update the stored word.
- Reset: asynchronous, active high; all outputs, the stored word and have_prev go to 0 immediately.
  - Reset mid-stream discards in-flight results.
  - The first valid G2B word after reset release is never flagged.

Test Plan:
- Exhaustive round trip: for each WIDTH 1..5, drive every bin 0..2^WIDTH-1 through B2G, then feed b2g_gray_out into G2B -> g2b_bin_out equals the original value after 2 cycles, and b2g_parity equals bin[0] for every value.
- Spot values, WIDTH = 4:
  - bin 1011 -> gray 1110, parity 1.
  - gray 1110 -> bin 1011.
  - bin 1111 -> gray 1000.
  - bin 0 -> gray 0, parity 0.
- Step checker, WIDTH = 4:
  - Gray sequence 0000, 0001, 0011, 0010 -> step_err 0,0,0,0.
  - Then 0010 -> 1.
  - Then 0111 -> 1 (distance 2).
  - Then 1000 -> 0000 wrap -> 0.
- Valid gating: b2g_valid_in low for 3 cycles -> b2g_valid_out 0 and b2g_gray_out unchanged. A valid gap between G2B words 0001 and 0011 -> step_err 0.
- Async reset: assert rst between clock edges with both valid_out = 1 -> all outputs 0 before the next edge. After release, first G2B word 0110 -> step_err 0.
- Simultaneous channels: B2G bin 0101 and G2B gray 0111 in the same cycle -> next cycle gray 0111 and bin 0101, both valid_out = 1.

Source files
------------

// File: rtl/gray_codec.sv
// gray_codec: two independent registered channels.
//   B2G encodes a binary word to Gray code and registers its parity alongside.
//   G2B decodes a Gray word to binary and flags any step that is not a single-bit change.
// Both channels have a one-clock latency and hold their data on idle cycles.
module gray_codec #(
    parameter int WIDTH = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b2g_valid_in,
    input  logic [WIDTH-1:0] b2g_bin_in,
    output logic             b2g_valid_out,
    output logic [WIDTH-1:0] b2g_gray_out,
    output logic             b2g_parity,
    input  logic             g2b_valid_in,
    input  logic [WIDTH-1:0] g2b_gray_in,
    output logic             g2b_valid_out,
    output logic [WIDTH-1:0] g2b_bin_out,
    output logic             g2b_step_err
);

    if (WIDTH < 32'sd1) begin : g_bad_width
        $error("gray_codec: WIDTH must be at least 1");
    end

    // Binary to Gray: each bit is XORed with its upper neighbour; the MSB passes through.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bin_v);
        return bin_v ^ (bin_v >> 32'd1);
    endfunction

    // Gray to binary: a running XOR from the MSB downwards.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] gray_v);
        logic [WIDTH-1:0] bin_v;
        bin_v = gray_v;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin_v[i] = bin_v[i+1] ^ gray_v[i];
        end
        return bin_v;
    endfunction

    // Even/odd parity of a word.
    function automatic logic parity_of(input logic [WIDTH-1:0] word_v);
        return ^word_v;
    endfunction

    // True when two words differ in exactly one bit, i.e. the XOR is a non-zero power of two.
    function automatic logic is_unit_step(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v);
        logic [WIDTH-1:0] diff_v;
        diff_v = a_v ^ b_v;
        return (diff_v != {WIDTH{1'b0}}) &&
               ((diff_v & (diff_v - WIDTH'(1'b1))) == {WIDTH{1'b0}});
    endfunction

    logic [WIDTH-1:0] b2g_gray_s;
    logic             b2g_parity_s;
    logic [WIDTH-1:0] g2b_bin_s;
    logic             g2b_step_err_s;

    logic             b2g_valid_r;
    logic [WIDTH-1:0] b2g_gray_r;
    logic             b2g_parity_r;
    logic             g2b_valid_r;
    logic [WIDTH-1:0] g2b_bin_r;
    logic             g2b_step_err_r;
    logic [WIDTH-1:0] prev_gray_r;
    logic             have_prev_r;

    // Next-result logic for both channels; the step flag only fires on a valid word that has a predecessor.
    always_comb begin
        b2g_gray_s     = bin_to_gray(b2g_bin_in);
        b2g_parity_s   = parity_of(b2g_gray_s);
        g2b_bin_s      = gray_to_bin(g2b_gray_in);
        g2b_step_err_s = 1'b0;
        if (g2b_valid_in && have_prev_r) begin
            g2b_step_err_s = !is_unit_step(g2b_gray_in, prev_gray_r);
        end else begin
            g2b_step_err_s = 1'b0;
        end
    end

    // B2G result register: capture on valid, otherwise hold data and drop valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b2g_valid_r  <= 1'b0;
            b2g_gray_r   <= {WIDTH{1'b0}};
            b2g_parity_r <= 1'b0;
        end else begin
            b2g_valid_r <= b2g_valid_in;
            if (b2g_valid_in) begin
                b2g_gray_r   <= b2g_gray_s;
                b2g_parity_r <= b2g_parity_s;
            end
        end
    end

    // G2B result register plus the stored previous word used by the step checker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g2b_valid_r    <= 1'b0;
            g2b_bin_r      <= {WIDTH{1'b0}};
            g2b_step_err_r <= 1'b0;
            prev_gray_r    <= {WIDTH{1'b0}};
            have_prev_r    <= 1'b0;
        end else begin
            g2b_valid_r    <= g2b_valid_in;
            g2b_step_err_r <= g2b_step_err_s;
            if (g2b_valid_in) begin
                g2b_bin_r   <= g2b_bin_s;
                prev_gray_r <= g2b_gray_in;
                have_prev_r <= 1'b1;
            end
        end
    end

    assign b2g_valid_out = b2g_valid_r;
    assign b2g_gray_out  = b2g_gray_r;
    assign b2g_parity    = b2g_parity_r;
    assign g2b_valid_out = g2b_valid_r;
    assign g2b_bin_out   = g2b_bin_r;
    assign g2b_step_err  = g2b_step_err_r;

endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench for gray_codec: a WIDTH=4 instance under directed and random
// stimulus, plus chained WIDTH=1 and WIDTH=5 instances for exhaustive round trips.
module tb_gray_codec;

    logic clk;
    logic rst;

    // Main WIDTH=4 instance.
    logic       b2g_valid_in, b2g_valid_out, b2g_parity;
    logic [3:0] b2g_bin_in, b2g_gray_out;
    logic       g2b_valid_in, g2b_valid_out, g2b_step_err;
    logic [3:0] g2b_gray_in, g2b_bin_out;

    gray_codec #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .b2g_valid_in(b2g_valid_in), .b2g_bin_in(b2g_bin_in),
        .b2g_valid_out(b2g_valid_out), .b2g_gray_out(b2g_gray_out), .b2g_parity(b2g_parity),
        .g2b_valid_in(g2b_valid_in), .g2b_gray_in(g2b_gray_in),
        .g2b_valid_out(g2b_valid_out), .g2b_bin_out(g2b_bin_out), .g2b_step_err(g2b_step_err)
    );

    // WIDTH=1 instance, encoder output chained into decoder input.
    logic       w1_v, w1_bv, w1_par, w1_gv, w1_err;
    logic [0:0] w1_bin, w1_gray, w1_dec;
    gray_codec #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst),
        .b2g_valid_in(w1_v), .b2g_bin_in(w1_bin),
        .b2g_valid_out(w1_bv), .b2g_gray_out(w1_gray), .b2g_parity(w1_par),
        .g2b_valid_in(w1_bv), .g2b_gray_in(w1_gray),
        .g2b_valid_out(w1_gv), .g2b_bin_out(w1_dec), .g2b_step_err(w1_err)
    );

    // WIDTH=5 instance, encoder output chained into decoder input.
    logic       w5_v, w5_bv, w5_par, w5_gv, w5_err;
    logic [4:0] w5_bin, w5_gray, w5_dec;
    gray_codec #(.WIDTH(5)) u_w5 (
        .clk(clk), .rst(rst),
        .b2g_valid_in(w5_v), .b2g_bin_in(w5_bin),
        .b2g_valid_out(w5_bv), .b2g_gray_out(w5_gray), .b2g_parity(w5_par),
        .g2b_valid_in(w5_bv), .g2b_gray_in(w5_gray),
        .g2b_valid_out(w5_gv), .g2b_bin_out(w5_dec), .g2b_step_err(w5_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model state for the WIDTH=4 instance.
    logic       exp_bvalid, exp_par, exp_gvalid, exp_err, m_have;
    logic [3:0] exp_gray, exp_bin, m_prev;

    // Gray code of n built by reflection: the code list for w bits is the (w-1)-bit
    // list followed by its mirror image with the new top bit set.
    function automatic int ref_gray(input int w, input int n);
        int q[$];
        q.push_back(0);
        for (int k = 0; k < w; k++) begin
            for (int i = q.size() - 1; i >= 0; i--) q.push_back(q[i] | (1 << k));
        end
        return q[n];
    endfunction

    // Decoding is the position of the code in the reflected list.
    function automatic int ref_bin(input int w, input int g);
        for (int n = 0; n < (1 << w); n++) if (ref_gray(w, n) == g) return n;
        return -1;
    endfunction

    function automatic int popcount(input int v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += (v >> i) & 1;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag);
        chk({tag, ".b2g_valid"}, 32'(b2g_valid_out), 32'(exp_bvalid));
        chk({tag, ".b2g_gray"},  32'(b2g_gray_out),  32'(exp_gray));
        chk({tag, ".b2g_par"},   32'(b2g_parity),    32'(exp_par));
        chk({tag, ".g2b_valid"}, 32'(g2b_valid_out), 32'(exp_gvalid));
        chk({tag, ".g2b_bin"},   32'(g2b_bin_out),   32'(exp_bin));
        chk({tag, ".g2b_err"},   32'(g2b_step_err),  32'(exp_err));
    endtask

    task automatic model_reset();
        exp_bvalid = 1'b0; exp_gray = 4'd0; exp_par = 1'b0;
        exp_gvalid = 1'b0; exp_bin = 4'd0; exp_err = 1'b0;
        m_have = 1'b0; m_prev = 4'd0;
    endtask

    // One clock on the main instance, then compare against the model.
    task automatic cyc(input string tag, input logic bv, input logic [3:0] bin,
                       input logic gv, input logic [3:0] g);
        b2g_valid_in = bv; b2g_bin_in = bin;
        g2b_valid_in = gv; g2b_gray_in = g;
        @(posedge clk); #1;
        exp_bvalid = bv;
        if (bv) begin
            exp_gray = 4'(ref_gray(4, int'(bin)));
            exp_par  = 1'(popcount(int'(exp_gray)) % 2);
        end
        exp_gvalid = gv;
        exp_err    = 1'b0;
        if (gv) begin
            exp_err = m_have && (popcount(int'(g ^ m_prev)) != 1);
            exp_bin = 4'(ref_bin(4, int'(g)));
            m_prev  = g;
            m_have  = 1'b1;
        end
        chk_main(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge.
    task automatic pulse_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_main(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rb, rg;
        logic       rbv, rgv;
        vectors = 0; miscompares = 0;
        rst = 1'b1;
        b2g_valid_in = 1'b0; b2g_bin_in = 4'd0; g2b_valid_in = 1'b0; g2b_gray_in = 4'd0;
        w1_v = 1'b0; w1_bin = 1'b0; w5_v = 1'b0; w5_bin = 5'd0;
        model_reset();
        #1 chk_main("reset");
        @(posedge clk); #1 chk_main("reset_hold");
        #2 rst = 1'b0;

        // Exhaustive round trip on the chained WIDTH=1 and WIDTH=5 instances.
        for (int n = 0; n < 32; n++) begin
            w5_v = 1'b1; w5_bin = 5'(n);
            w1_v = 1'b1; w1_bin = 1'(n);
            @(posedge clk); #1;
            chk("w5.gray", 32'(w5_gray), 32'(ref_gray(5, n)));
            chk("w5.par",  32'(w5_par),  32'(n & 1));
            chk("w5.bv",   32'(w5_bv),   32'd1);
            if (n < 2) begin
                chk("w1.gray", 32'(w1_gray), 32'(n));
                chk("w1.par",  32'(w1_par),  32'(n & 1));
            end
            w5_v = 1'b0; w1_v = 1'b0;
            @(posedge clk); #1;
            chk("w5.rt",  32'(w5_dec), 32'(n));
            chk("w5.gv",  32'(w5_gv),  32'd1);
            chk("w5.bvl", 32'(w5_bv),  32'd0);
            if (n < 2) chk("w1.rt", 32'(w1_dec), 32'(n));
        end

        // Exhaustive round trip on the main instance: encode, then decode the model's code.
        for (int n = 0; n < 16; n++) begin
            cyc("rt_enc", 1'b1, 4'(n), 1'b0, 4'd0);
            chk("rt_par", 32'(b2g_parity), 32'(n & 1));
            cyc("rt_dec", 1'b0, 4'd0, 1'b1, b2g_gray_out);
            chk("rt_bin", 32'(g2b_bin_out), 32'(n));
        end

        // Spot values.
        pulse_reset("rst_spot");
        cyc("spot1", 1'b1, 4'b1011, 1'b1, 4'b1110);
        chk("spot1.gray", 32'(b2g_gray_out), 32'b1110);
        chk("spot1.par",  32'(b2g_parity),   32'd1);
        chk("spot1.bin",  32'(g2b_bin_out),  32'b1011);
        chk("spot1.err",  32'(g2b_step_err), 32'd0);
        cyc("spot2", 1'b1, 4'b1111, 1'b0, 4'd0);
        chk("spot2.gray", 32'(b2g_gray_out), 32'b1000);
        cyc("spot3", 1'b1, 4'b0000, 1'b0, 4'd0);
        chk("spot3.gray", 32'(b2g_gray_out), 32'd0);
        chk("spot3.par",  32'(b2g_parity),   32'd0);

        // Step checker sequence from a fresh reset.
        pulse_reset("rst_step");
        cyc("st0", 1'b0, 4'd0, 1'b1, 4'b0000);
        cyc("st1", 1'b0, 4'd0, 1'b1, 4'b0001);
        cyc("st2", 1'b0, 4'd0, 1'b1, 4'b0011);
        cyc("st3", 1'b0, 4'd0, 1'b1, 4'b0010);
        chk("st3.err", 32'(g2b_step_err), 32'd0);
        cyc("st_rep", 1'b0, 4'd0, 1'b1, 4'b0010);
        chk("st_rep.err", 32'(g2b_step_err), 32'd1);
        cyc("st_d2", 1'b0, 4'd0, 1'b1, 4'b0111);
        chk("st_d2.err", 32'(g2b_step_err), 32'd1);
        cyc("st_max", 1'b0, 4'd0, 1'b1, 4'b1000);
        cyc("st_wrap", 1'b0, 4'd0, 1'b1, 4'b0000);
        chk("st_wrap.err", 32'(g2b_step_err), 32'd0);
        chk("st_wrap.bin", 32'(g2b_bin_out),  32'd0);

        // Valid gating: B2G holds through three idle cycles, G2B gap is not a step.
        cyc("gate0", 1'b1, 4'b0110, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            cyc("gate_idle", 1'b0, 4'b1111, 1'b0, 4'b1111);
            chk("gate.gray", 32'(b2g_gray_out), 32'b0101);
            chk("gate.err",  32'(g2b_step_err), 32'd0);
        end
        cyc("gate_g", 1'b0, 4'd0, 1'b1, 4'b0011);
        chk("gate_g.err", 32'(g2b_step_err), 32'd0);

        // Async reset with both channels valid, then the first word is never flagged.
        cyc("pre_rst", 1'b1, 4'b1001, 1'b1, 4'b0010);
        chk("pre_rst.bv", 32'(b2g_valid_out), 32'd1);
        chk("pre_rst.gv", 32'(g2b_valid_out), 32'd1);
        pulse_reset("async_rst");
        cyc("post_rst", 1'b0, 4'd0, 1'b1, 4'b0110);
        chk("post_rst.err", 32'(g2b_step_err), 32'd0);

        // Simultaneous channels.
        cyc("simul", 1'b1, 4'b0101, 1'b1, 4'b0111);
        chk("simul.gray", 32'(b2g_gray_out), 32'b0111);
        chk("simul.bin",  32'(g2b_bin_out),  32'b0101);

        // Randomised traffic; G2B mostly walks by single-bit flips to exercise both step outcomes.
        for (int i = 0; i < 300; i++) begin
            rbv = ($urandom_range(0, 3) != 0);
            rgv = ($urandom_range(0, 3) != 0);
            rb  = 4'($urandom);
            if ($urandom_range(0, 2) == 0) rg = 4'($urandom);
            else rg = m_prev ^ 4'(1 << $urandom_range(0, 3));
            cyc("rand", rbv, rb, rgv, rg);
            if ($urandom_range(0, 99) == 0) pulse_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
